crc8_stream: RTL and testbench

CRC8_STREAM -- requirements
Module: crc8_stream

---
 rtl/crc8_stream.sv | 155 +++++++++++++++
 tb/tb_crc8_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_stream.sv
// -----------------------------------------------------------------------------
// crc8_stream
//   Computes a CRC-8 (MSB first, no reflection, no final XOR) and a saturating
//   byte count over packets delimited by in_sop / in_eop, one byte per clock.
//   The result is held on out_crc / out_len with out_valid until the consumer
//   takes it; the input side is stalled (in_ready = 0) while a result waits.
//
// Parameters
//   POLY      generator polynomial, implicit x^8 term
//   INIT      CRC register value at the start of every packet
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  beat qualifier for in_data / in_sop / in_eop
//   in_ready  block can accept a beat this cycle
//   in_data   payload byte
//   in_sop    first byte of packet
//   in_eop    last byte of packet
//   out_valid result available
//   out_ready consumer accepts result
//   out_crc   final CRC of packet
//   out_len   byte count of packet, saturates at 16'hFFFF
//   err       one-cycle pulse on a protocol violation
//
// State   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for an sop beat; non-sop beats are dropped and flagged
// ACCUM   | inside a packet, folding bytes into the CRC
// DONE    | result presented on out_*, input stalled until out_ready
// -----------------------------------------------------------------------------
module crc8_stream #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_crc,
    output logic [15:0] out_len,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic        beat_acc;
    logic [7:0]  crc_from_init;
    logic [7:0]  crc_from_run;

    // Eight unrolled shift/XOR steps; synthesises to a flat XOR network so a
    // full byte is absorbed every cycle.
    function automatic logic [7:0] crc8_fold(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = (c << 1) ^ POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    assign in_ready      = (state_q != ST_DONE);
    assign beat_acc      = in_valid && in_ready;
    assign crc_from_init = crc8_fold(INIT, in_data);
    assign crc_from_run  = crc8_fold(crc_q, in_data);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (beat_acc) begin
                    if (in_sop) begin
                        crc_d   = crc_from_init;
                        len_d   = 16'd1;
                        state_d = in_eop ? ST_DONE : ST_ACCUM;
                    end else begin
                        // Orphan byte outside a packet: drop it, keep the
                        // previous result visible on out_*.
                        err_d = 1'b1;
                    end
                end
            end

            ST_ACCUM: begin
                if (beat_acc) begin
                    if (in_sop) begin
                        // Unexpected sop restarts the packet from this byte.
                        err_d   = 1'b1;
                        crc_d   = crc_from_init;
                        len_d   = 16'd1;
                        state_d = in_eop ? ST_DONE : ST_ACCUM;
                    end else begin
                        crc_d   = crc_from_run;
                        len_d   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                        state_d = in_eop ? ST_DONE : ST_ACCUM;
                    end
                end
            end

            ST_DONE: begin
                // in_ready is low here, so nothing is accepted even in the
                // handshake cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            len_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign out_crc   = crc_q;
    assign out_len   = len_q;
    assign err       = err_q;

endmodule

// File: tb/tb_crc8_stream.sv
module tb_crc8_stream;

    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_crc;
    logic [15:0] out_len;
    logic        err;

    int checks = 0;
    int errors = 0;

    crc8_stream #(.POLY(POLY), .INIT(INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_len   (out_len),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_fold(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [7:0]  crc;
        logic [15:0] len;
    } res_t;

    res_t        sb_q[$];
    logic [1:0]  m_state;   // 0 idle, 1 accum, 2 done
    logic [7:0]  m_crc;
    logic [15:0] m_len;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 2'd0;
            m_crc   <= INIT;
            m_len   <= 16'd0;
            m_err   <= 1'b0;
            sb_q.delete();
        end else begin
            m_err <= 1'b0;
            if (in_valid && m_state != 2'd2) begin
                if (in_sop) begin
                    m_crc   <= ref_fold(INIT, in_data);
                    m_len   <= 16'd1;
                    m_err   <= (m_state == 2'd1);
                    m_state <= in_eop ? 2'd2 : 2'd1;
                    if (in_eop) sb_q.push_back({ref_fold(INIT, in_data), 16'd1});
                end else if (m_state == 2'd1) begin
                    m_crc   <= ref_fold(m_crc, in_data);
                    m_len   <= (m_len == 16'hFFFF) ? m_len : m_len + 16'd1;
                    m_state <= in_eop ? 2'd2 : 2'd1;
                    if (in_eop)
                        sb_q.push_back({ref_fold(m_crc, in_data),
                                        (m_len == 16'hFFFF) ? m_len : m_len + 16'd1});
                end else begin
                    m_err <= 1'b1;
                end
            end else if (m_state == 2'd2 && out_ready) begin
                m_state <= 2'd0;
            end
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            check("rst_out_crc", out_crc, INIT);
            check("rst_out_len", out_len, 16'd0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_err", err, 1'b0);
        end else begin
            check("in_ready", in_ready, m_state != 2'd2);
            check("out_valid", out_valid, m_state == 2'd2);
            check("err", err, m_err);
            if (m_state == 2'd2) begin
                check("hold_crc", out_crc, m_crc);
                check("hold_len", out_len, m_len);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=result required=none");
                end else begin
                    r = sb_q.pop_front();
                    check("sb_crc", out_crc, r.crc);
                    check("sb_len", out_len, r.len);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        sync();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Called right after the eop beat: result must be up one cycle later.
    task automatic expect_done(input string name, input logic [7:0] c, input logic [15:0] l);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_crc"}, out_crc, c);
        check({name, "_len"}, out_len, l);
        sync();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] crc;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [7:0] rc;
        logic [7:0] d;

        vt[0] = '{8'h01, 8'h07};
        vt[1] = '{8'h00, 8'h00};
        vt[2] = '{8'h02, 8'h0E};
        vt[3] = '{8'h80, 8'h89};
        vt[4] = '{8'hFF, 8'hF3};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        sync();

        // single-beat packets from the table
        for (int i = 0; i < 5; i++) begin
            beat(vt[i].data, 1'b1, 1'b1);
            expect_done($sformatf("single%0d", i), vt[i].crc, 16'd1);
        end

        // check string
        for (int i = 0; i < 9; i++) beat(8'h31 + 8'(i), i == 0, i == 8);
        expect_done("check123", 8'hF4, 16'd9);

        // back-pressure in DONE, stray beats offered throughout
        out_ready = 1'b0;
        beat(8'h01, 1'b1, 1'b1);
        in_valid = 1'b1; in_data = 8'h55; in_sop = 1'b1; in_eop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_crc", out_crc, 8'h07);
            check("stall_len", out_len, 16'd1);
            check("stall_in_ready", in_ready, 1'b0);
            sync();
        end
        out_ready = 1'b1;
        sync();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(negedge clk);
        check("release_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        check("release_crc", out_crc, 8'h07);
        check("release_len", out_len, 16'd1);
        sync();

        // orphan byte in IDLE
        beat(8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        check("orphan_err", err, 1'b1);
        check("orphan_valid", out_valid, 1'b0);
        check("orphan_crc", out_crc, 8'h07);
        check("orphan_len", out_len, 16'd1);
        sync();
        @(negedge clk);
        check("orphan_err_clear", err, 1'b0);
        sync();

        // sop mid-packet restarts from INIT
        beat(8'h31, 1'b1, 1'b0);
        beat(8'h32, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b1);
        @(negedge clk);
        check("restart_err", err, 1'b1);
        check("restart_crc", out_crc, 8'h07);
        check("restart_len", out_len, 16'd1);
        sync();
        @(negedge clk);
        check("restart_err_clear", err, 1'b0);
        sync();

        // reset after four bytes
        for (int i = 0; i < 4; i++) beat(8'h31 + 8'(i), i == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_crc", out_crc, INIT);
        check("midrst_len", out_len, 16'd0);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync();
        sync();
        for (int i = 0; i < 9; i++) beat(8'h31 + 8'(i), i == 0, i == 8);
        expect_done("after_rst", 8'hF4, 16'd9);

        // long packet, length saturates
        rc = INIT;
        for (int i = 0; i < 70000; i++) begin
            d  = 8'($urandom);
            rc = ref_fold(rc, d);
            beat(d, i == 0, i == 69999);
        end
        expect_done("long", rc, 16'hFFFF);

        sync();
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
